// File: rtl/ddc_nco_pkg.sv
// rtl/ddc_nco_pkg.sv - shared widths, scheduler state and hop table entry type for the DDC NCO
package ddc_nco_pkg;

    localparam int FW        = 12;
    localparam int DW        = 16;
    localparam int TBL_DEPTH = 4;
    localparam int IW        = $clog2(TBL_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_WRAP
    } sched_state_t;

    typedef struct packed {
        logic [FW-1:0] freq;
        logic [DW-1:0] dwell;
    } tbl_entry_t;

    // A programmed dwell of zero still occupies one clock.
    function automatic logic [DW-1:0] dwell_min1(input logic [DW-1:0] d);
        return (d == '0) ? DW'(1) : d;
    endfunction

endpackage

// File: rtl/ddc_nco_phase_acc.sv
// rtl/ddc_nco_phase_acc.sv - modulo-2^W phase accumulator with registered ROM address and carry-out wrap flag
module ddc_nco_phase_acc #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] addr,
    output logic         wrap
);

    logic [W-1:0] acc;
    logic [W:0]   sum;

    // wrap reflects the carry of the addition being committed at the coming edge
    assign sum  = {1'b0, acc} + {1'b0, inc};
    assign wrap = sum[W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc  <= '0;
            addr <= '0;
        end else begin
            acc  <= clr ? '0 : sum[W-1:0];
            addr <= acc;
        end
    end

endmodule

// File: rtl/ddc_nco_hop_sched.sv
// rtl/ddc_nco_hop_sched.sv - frequency-hop table, dwell counter and scheduler FSM driving the NCO phase accumulator
module ddc_nco_hop_sched
    import ddc_nco_pkg::*;
(
    input  logic          Clk_20P48,
    input  logic          resetn,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [FW-1:0] cfg_freq,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [IW-1:0] cfg_last,
    input  logic          phase_align,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          hop_strobe,
    output logic [IW-1:0] hop_idx,
    output logic [FW-1:0] NCO_Freq,
    output logic [FW-1:0] NCO_Addr
);

    sched_state_t  state, state_nxt;
    tbl_entry_t    tbl [TBL_DEPTH];
    logic [DW-1:0] dwell_cnt;
    logic [IW-1:0] pend_idx;
    logic [IW-1:0] exp_idx;
    logic [IW-1:0] load_idx;
    logic          load;
    logic          clr_acc;
    logic          arm_wait;
    logic          wrap;

    always_ff @(posedge Clk_20P48 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cfg_last is sampled at expiry; an index already past it restarts the sequence
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = '0;
        clr_acc   = 1'b0;
        arm_wait  = 1'b0;
        exp_idx   = (hop_idx >= cfg_last) ? '0 : hop_idx + 1'b1;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                        clr_acc   = 1'b1;
                    end
                end
                RUN: begin
                    if (dwell_cnt <= DW'(1)) begin
                        if (phase_align) begin
                            state_nxt = WAIT_WRAP;
                            arm_wait  = 1'b1;
                        end else begin
                            load     = 1'b1;
                            load_idx = exp_idx;
                        end
                    end
                end
                WAIT_WRAP: begin
                    if (wrap) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                        load_idx  = pend_idx;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_20P48 or negedge resetn) begin
        if (!resetn) begin
            NCO_Freq   <= '0;
            dwell_cnt  <= '0;
            hop_idx    <= '0;
            hop_strobe <= 1'b0;
            pend_idx   <= '0;
        end else begin
            hop_strobe <= load;
            if (stop) begin
                NCO_Freq <= '0;
            end else if (load) begin
                NCO_Freq  <= tbl[load_idx].freq;
                dwell_cnt <= dwell_min1(tbl[load_idx].dwell);
                hop_idx   <= load_idx;
            end else if (state == RUN) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end
            if (arm_wait) begin
                pend_idx <= exp_idx;
            end
        end
    end

    // a load in the same cycle as a write to that entry reads the pre-write value
    always_ff @(posedge Clk_20P48 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl[cfg_idx] <= {cfg_freq, cfg_dwell};
        end
    end

    assign busy = (state != IDLE);

    ddc_nco_phase_acc #(
        .W(FW)
    ) u_phase_acc (
        .clk    (Clk_20P48),
        .resetn (resetn),
        .clr    (clr_acc),
        .inc    (NCO_Freq),
        .addr   (NCO_Addr),
        .wrap   (wrap)
    );

endmodule

// File: tb/tb_ddc_nco_hop_sched.sv
// tb/tb_ddc_nco_hop_sched.sv - directed and randomized checks of ddc_nco_hop_sched against a behavioural hop model
`timescale 1ns/1ps
module tb_ddc_nco_hop_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [11:0] cfg_freq = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_last = '0;
    logic        phase_align = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic        hop_strobe;
    logic [1:0]  hop_idx;
    logic [11:0] NCO_Freq;
    logic [11:0] NCO_Addr;

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0 idle, 1 running, 2 waiting for a wrap
    int m_mode, m_idx, m_rem, m_pend, m_freq, m_acc, m_addr, m_strobe;
    int m_tf[4];
    int m_td[4];
    int a_frozen;

    always #24.414 clk = ~clk;

    ddc_nco_hop_sched dut (
        .Clk_20P48   (clk),
        .resetn      (resetn),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_freq    (cfg_freq),
        .cfg_dwell   (cfg_dwell),
        .cfg_last    (cfg_last),
        .phase_align (phase_align),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .hop_strobe  (hop_strobe),
        .hop_idx     (hop_idx),
        .NCO_Freq    (NCO_Freq),
        .NCO_Addr    (NCO_Addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_rem = 0; m_pend = 0;
        m_freq = 0; m_acc = 0; m_addr = 0; m_strobe = 0;
        for (int i = 0; i < 4; i++) begin
            m_tf[i] = 0;
            m_td[i] = 0;
        end
    endtask

    function automatic int next_of(input int i);
        return (i >= int'(cfg_last)) ? 0 : i + 1;
    endfunction

    task automatic m_load(input int i);
        m_freq   = m_tf[i];
        m_rem    = (m_td[i] == 0) ? 1 : m_td[i];
        m_idx    = i;
        m_strobe = 1;
        m_mode   = 1;
    endtask

    task automatic model_step();
        int sum;
        int wrap_now;
        sum      = m_acc + m_freq;
        wrap_now = (sum >= 4096);
        m_addr   = m_acc;
        m_acc    = sum % 4096;
        m_strobe = 0;
        if (stop) begin
            m_mode = 0;
            m_freq = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_load(0);
                m_acc = 0;
            end
        end else if (m_mode == 1) begin
            if (m_rem == 1) begin
                if (phase_align) begin
                    m_mode = 2;
                    m_pend = next_of(m_idx);
                end else begin
                    m_load(next_of(m_idx));
                end
            end else begin
                m_rem--;
            end
        end else if (wrap_now) begin
            m_load(m_pend);
        end
        if (cfg_we) begin
            m_tf[cfg_idx] = int'(cfg_freq);
            m_td[cfg_idx] = int'(cfg_dwell);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("freq", NCO_Freq, m_freq);
        check_eq("addr", NCO_Addr, m_addr);
        check_eq("busy", busy, (m_mode != 0) ? 1 : 0);
        check_eq("strobe", hop_strobe, m_strobe);
        check_eq("hop_idx", hop_idx, m_idx);
    endtask

    task automatic write_entry(input int idx, input int f, input int d);
        cfg_we    = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_freq  = 12'(f);
        cfg_dwell = 16'(d);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_freq"}, NCO_Freq, 0);
        check_eq({tag, "_addr"}, NCO_Addr, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_strobe"}, hop_strobe, 0);
        check_eq({tag, "_idx"}, hop_idx, 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    int exp_f2[8] = '{992, 992, 992, 992, 100, 100, 100, 992};
    int exp_a2[8] = '{0, 0, 992, 1984, 2976, 3968, 4068, 72};
    int exp_s2[8] = '{1, 0, 0, 0, 1, 0, 0, 1};
    int exp_f3[6] = '{1024, 1024, 1024, 1024, 7, 7};
    int exp_s3[6] = '{1, 0, 0, 0, 1, 0};
    int exp_f4[4] = '{5, 9, 9, 5};
    int exp_s4[4] = '{1, 1, 0, 1};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        repeat (100) cycle();
        check_eq("idle_addr", NCO_Addr, 0);
        check_eq("idle_busy", busy, 0);

        // two-entry run without phase alignment
        write_entry(0, 992, 4);
        write_entry(1, 100, 3);
        cfg_last    = 2'd1;
        phase_align = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            start = 1'b0;
            check_eq("seq_freq", NCO_Freq, exp_f2[i]);
            check_eq("seq_addr", NCO_Addr, exp_a2[i]);
            check_eq("seq_strobe", hop_strobe, exp_s2[i]);
            check_eq("seq_idx", hop_idx, (i >= 4 && i < 7) ? 1 : 0);
        end
        repeat (20) cycle();

        // phase-aligned hop waits for the accumulator carry
        do_stop();
        write_entry(0, 1024, 2);
        write_entry(1, 7, 2);
        phase_align = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            start = 1'b0;
            check_eq("pa_freq", NCO_Freq, exp_f3[i]);
            check_eq("pa_strobe", hop_strobe, exp_s3[i]);
            if (i == 4) check_eq("pa_addr", NCO_Addr, 3072);
        end
        repeat (10) cycle();

        // zero dwell behaves as one cycle
        do_stop();
        phase_align = 1'b0;
        write_entry(0, 5, 0);
        write_entry(1, 9, 2);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            start = 1'b0;
            check_eq("dw0_freq", NCO_Freq, exp_f4[i]);
            check_eq("dw0_strobe", hop_strobe, exp_s4[i]);
        end

        // write collides with the load of the same entry
        do_stop();
        write_entry(0, 11, 3);
        write_entry(1, 22, 2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_freq = 12'd500; cfg_dwell = 16'd2;
        cycle();
        cfg_we = 1'b0;
        check_eq("coll_old", NCO_Freq, 22);
        check_eq("coll_idx", hop_idx, 1);
        repeat (5) cycle();
        check_eq("coll_new", NCO_Freq, 500);
        check_eq("coll_new_idx", hop_idx, 1);

        // stop beats start while idle, then stop mid-run freezes the phase
        do_stop();
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check_eq("ss_busy", busy, 0);
        check_eq("ss_freq", NCO_Freq, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        do_stop();
        check_eq("stop_freq", NCO_Freq, 0);
        check_eq("stop_busy", busy, 0);
        cycle();
        a_frozen = m_addr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("stop_freeze", NCO_Addr, a_frozen);
        end

        // randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 2500; n++) begin
            cfg_we    = ($urandom_range(3) == 0);
            cfg_idx   = 2'($urandom_range(3));
            cfg_freq  = 12'($urandom);
            cfg_dwell = 16'($urandom_range(6));
            if ($urandom_range(49) == 0) cfg_last = 2'($urandom_range(3));
            if ($urandom_range(99) == 0) phase_align = ~phase_align;
            start = ($urandom_range(19) == 0);
            stop  = ($urandom_range(59) == 0);
            if (n == 1200) begin
                resetn = 1'b0;
                #2;
                check_zero("midreset");
                model_reset();
                @(negedge clk);
                resetn = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
